// File: rtl/l2_line_responder.sv
// Line-granular L2 backing store: single-cycle line writes, fixed-latency line reads.
// Optional macro L2_RESP_PERF_EN adds read/write handshake counters (rd_cnt, wr_cnt).
module l2_line_responder #(
  parameter  int ADDR_W        = 32,
  parameter  int L1_LINE_BYTES = 32,
  parameter  int MEM_LINES     = 64,
  parameter  int RD_LAT        = 4,
  localparam int L1_LINE_W     = L1_LINE_BYTES * 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 l2_req_valid,
  output logic                 l2_req_ready,
  input  logic                 l2_req_rw,
  input  logic [ADDR_W-1:0]    l2_req_addr,
  input  logic [L1_LINE_W-1:0] l2_req_wline,
`ifdef L2_RESP_PERF_EN
  output logic [31:0]          rd_cnt,
  output logic [31:0]          wr_cnt,
`endif
  output logic                 l2_resp_valid,
  output logic [L1_LINE_W-1:0] l2_resp_rline
);

  localparam int OFFSET_BITS = $clog2(L1_LINE_BYTES);
  localparam int IDX_W       = $clog2(MEM_LINES);

  typedef enum logic {
    S_IDLE,
    S_RD_WAIT
  } state_t;

  state_t               state;
  state_t               state_next;
  logic [7:0]           cnt;
  logic [7:0]           cnt_next;
  logic [IDX_W-1:0]     req_idx;
  logic [IDX_W-1:0]     rd_idx;
  logic                 rd_hs;
  logic                 wr_hs;
  logic                 resp_fire;
  logic                 unused_addr;
  logic [L1_LINE_W-1:0] mem [MEM_LINES];

  // Offset and upper address bits are deliberately dropped, so aliases share a line.
  assign req_idx      = l2_req_addr[OFFSET_BITS +: IDX_W];
  assign unused_addr  = ^l2_req_addr;
  assign l2_req_ready = (state == S_IDLE);
  assign rd_hs        = l2_req_valid & l2_req_ready & ~l2_req_rw;
  assign wr_hs        = l2_req_valid & l2_req_ready &  l2_req_rw;

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    resp_fire  = 1'b0;
    case (state)
      S_IDLE: begin
        if (rd_hs) begin
          state_next = S_RD_WAIT;
          cnt_next   = 8'(RD_LAT - 1);
        end
      end
      S_RD_WAIT: begin
        if (cnt == 8'd0) begin
          resp_fire  = 1'b1;
          state_next = S_IDLE;
        end else begin
          cnt_next = cnt - 8'd1;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      cnt    <= 8'd0;
      rd_idx <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (rd_hs) rd_idx <= req_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      l2_resp_valid <= 1'b0;
      l2_resp_rline <= '0;
    end else begin
      l2_resp_valid <= resp_fire;
      if (resp_fire) l2_resp_rline <= mem[rd_idx];
    end
  end

  // Storage has no reset so it can map onto a RAM; reset still blocks writes.
  always_ff @(posedge clk) begin
    if (wr_hs && !rst) mem[req_idx] <= l2_req_wline;
  end

`ifdef L2_RESP_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_cnt <= 32'd0;
      wr_cnt <= 32'd0;
    end else begin
      if (rd_hs) rd_cnt <= rd_cnt + 32'd1;
      if (wr_hs) wr_cnt <= wr_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_l2_line_responder.sv
// Directed bench for l2_line_responder; checks reset, write/read, aliasing, busy blocking, reset abort.
// Defining L2_RESP_PERF_EN also exercises the rd_cnt/wr_cnt counters.
module tb_l2_line_responder;

  localparam int ADDR_W    = 32;
  localparam int LINE_W    = 256;
  localparam int RD_LAT    = 4;

  logic              clk;
  logic              rst;
  logic              l2_req_valid;
  logic              l2_req_ready;
  logic              l2_req_rw;
  logic [ADDR_W-1:0] l2_req_addr;
  logic [LINE_W-1:0] l2_req_wline;
  logic              l2_resp_valid;
  logic [LINE_W-1:0] l2_resp_rline;
`ifdef L2_RESP_PERF_EN
  logic [31:0]       rd_cnt;
  logic [31:0]       wr_cnt;
`endif

  int errors = 0;
  int checks = 0;

  l2_line_responder #(
    .ADDR_W(ADDR_W), .L1_LINE_BYTES(32), .MEM_LINES(64), .RD_LAT(RD_LAT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .l2_req_valid(l2_req_valid),
    .l2_req_ready(l2_req_ready),
    .l2_req_rw(l2_req_rw),
    .l2_req_addr(l2_req_addr),
    .l2_req_wline(l2_req_wline),
`ifdef L2_RESP_PERF_EN
    .rd_cnt(rd_cnt),
    .wr_cnt(wr_cnt),
`endif
    .l2_resp_valid(l2_resp_valid),
    .l2_resp_rline(l2_resp_rline)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1ns after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic rw,
                               input logic [ADDR_W-1:0] a, input logic [LINE_W-1:0] d);
    l2_req_valid = v;
    l2_req_rw    = rw;
    l2_req_addr  = a;
    l2_req_wline = d;
  endtask

  task automatic checkOutput(input string tag, input logic [LINE_W-1:0] observed,
                             input logic [LINE_W-1:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic writeLine(input logic [ADDR_W-1:0] a, input logic [LINE_W-1:0] d,
                           input string tag);
    applyStimulus(1'b1, 1'b1, a, d);
    tick();
    applyStimulus(1'b0, 1'b0, '0, '0);
    checkOutput({tag, "_ready"}, LINE_W'(l2_req_ready), LINE_W'(1));
    checkOutput({tag, "_novalid"}, LINE_W'(l2_resp_valid), LINE_W'(0));
  endtask

  // Read handshake, then ready low for RD_LAT cycles, then a one-cycle data pulse.
  task automatic readLine(input logic [ADDR_W-1:0] a, input logic [LINE_W-1:0] exp,
                          input string tag);
    applyStimulus(1'b1, 1'b0, a, '0);
    tick();
    applyStimulus(1'b0, 1'b0, '0, '0);
    for (int c = 0; c < RD_LAT; c++) begin
      checkOutput($sformatf("%s_busy%0d", tag, c), LINE_W'(l2_req_ready), LINE_W'(0));
      checkOutput($sformatf("%s_wait%0d", tag, c), LINE_W'(l2_resp_valid), LINE_W'(0));
      tick();
    end
    checkOutput({tag, "_valid"}, LINE_W'(l2_resp_valid), LINE_W'(1));
    checkOutput({tag, "_readyresp"}, LINE_W'(l2_req_ready), LINE_W'(1));
    checkOutput({tag, "_data"}, l2_resp_rline, exp);
    tick();
    checkOutput({tag, "_pulse"}, LINE_W'(l2_resp_valid), LINE_W'(0));
    checkOutput({tag, "_hold"}, l2_resp_rline, exp);
  endtask

  initial begin
    logic [LINE_W-1:0] patA5;
    logic [LINE_W-1:0] p0, p1, p2, p3, palias, pnew;
    patA5  = {32{8'hA5}};
    p0     = {8{32'h0000_1111}};
    p1     = {8{32'h2222_3333}};
    p2     = {8{32'h4444_5555}};
    p3     = {8{32'h6666_7777}};
    palias = {8{32'hDEAD_BEEF}};
    pnew   = {8{32'hC0FF_EE01}};

    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, '0, '0);
    tick();
    tick();
    rst = 1'b0;
    checkOutput("rst_ready", LINE_W'(l2_req_ready), LINE_W'(1));
    checkOutput("rst_valid", LINE_W'(l2_resp_valid), LINE_W'(0));
    checkOutput("rst_rline", l2_resp_rline, '0);

    writeLine(32'h0000_0040, patA5, "wrA5");
    readLine(32'h0000_0040, patA5, "rdA5");

    writeLine(32'h0000_0000, p0, "wr0");
    writeLine(32'h0000_0020, p1, "wr1");
    writeLine(32'h0000_0040, p2, "wr2");
    writeLine(32'h0000_0060, p3, "wr3");
    readLine(32'h0000_0000, p0, "rd0");
    readLine(32'h0000_0020, p1, "rd1");
    readLine(32'h0000_0040, p2, "rd2");
    readLine(32'h0000_0060, p3, "rd3");

    // Offset bits are ignored: 0x5F lands in the same line as 0x40.
    readLine(32'h0000_005F, p2, "rdoff");

    writeLine(32'h0000_0800, palias, "wralias");
    readLine(32'h0000_0000, palias, "rdalias");

    // A write held during the read wait must not land until the response cycle.
    applyStimulus(1'b1, 1'b0, 32'h0000_0020, '0);
    tick();
    applyStimulus(1'b1, 1'b1, 32'h0000_0020, pnew);
    for (int c = 0; c < RD_LAT; c++) begin
      checkOutput($sformatf("blk_busy%0d", c), LINE_W'(l2_req_ready), LINE_W'(0));
      tick();
    end
    checkOutput("blk_valid", LINE_W'(l2_resp_valid), LINE_W'(1));
    checkOutput("blk_ready", LINE_W'(l2_req_ready), LINE_W'(1));
    checkOutput("blk_olddata", l2_resp_rline, p1);
    tick();
    applyStimulus(1'b0, 1'b0, '0, '0);
    checkOutput("blk_wrdone_ready", LINE_W'(l2_req_ready), LINE_W'(1));
    readLine(32'h0000_0020, pnew, "rdnew");

    // Reset in the second wait cycle aborts the read.
    applyStimulus(1'b1, 1'b0, 32'h0000_0040, '0);
    tick();
    applyStimulus(1'b0, 1'b0, '0, '0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("abort_ready", LINE_W'(l2_req_ready), LINE_W'(1));
    checkOutput("abort_rline", l2_resp_rline, '0);
    for (int c = 0; c < RD_LAT + 1; c++) begin
      checkOutput($sformatf("abort_novalid%0d", c), LINE_W'(l2_resp_valid), LINE_W'(0));
      tick();
    end

`ifdef L2_RESP_PERF_EN
    rst = 1'b1;
    tick();
    rst = 1'b0;
    writeLine(32'h0000_0000, p0, "pwr0");
    writeLine(32'h0000_0020, p1, "pwr1");
    writeLine(32'h0000_0040, p2, "pwr2");
    readLine(32'h0000_0000, p0, "prd0");
    readLine(32'h0000_0020, p1, "prd1");
    checkOutput("perf_wr", LINE_W'(wr_cnt), LINE_W'(3));
    checkOutput("perf_rd", LINE_W'(rd_cnt), LINE_W'(2));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("perf_wr_rst", LINE_W'(wr_cnt), LINE_W'(0));
    checkOutput("perf_rd_rst", LINE_W'(rd_cnt), LINE_W'(0));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
